// File: rtl/floo_wormhole_arbiter.sv
// Output-port arbiter for the FlooNoC crossbar: round-robin at packet boundaries,
// wormhole lock from the first beat of a packet until its last-beat handshake.
module floo_wormhole_arbiter #(
    parameter int unsigned NumInputs = 4,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned CntWidth  = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumInputs-1:0]                valid_i,
    output logic [NumInputs-1:0]                ready_o,
    input  logic [NumInputs-1:0][DataWidth-1:0] data_i,
    input  logic [NumInputs-1:0]                last_i,
    output logic                                valid_o,
    input  logic                                ready_i,
    output logic [DataWidth-1:0]                data_o,
    output logic                                last_o,
    output logic [NumInputs-1:0]                gnt_o,
    output logic                                locked_o,
    output logic [CntWidth-1:0]                 pkt_cnt_o
);
    localparam int unsigned IdxW = $clog2(NumInputs);
    typedef logic [IdxW-1:0] idx_t;
    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                state_q;
    idx_t                  lock_idx_q, rr_ptr_q;
    logic [CntWidth-1:0]   pkt_cnt_q;

    idx_t rr_sel, cand, sel, rr_ptr_d;
    logic rr_found, sel_vld, hs;

    // Descending scan so the candidate closest to rr_ptr is written last and wins.
    always_comb begin
        rr_found = 1'b0;
        rr_sel   = '0;
        cand     = '0;
        for (int k = NumInputs - 1; k >= 0; k--) begin
            cand = idx_t'((int'(rr_ptr_q) + k) % NumInputs);
            if (valid_i[cand]) begin
                rr_found = 1'b1;
                rr_sel   = cand;
            end
        end
    end

    assign sel      = (state_q == LOCKED) ? lock_idx_q : rr_sel;
    assign sel_vld  = !rst_i && ((state_q == LOCKED) || rr_found);
    assign rr_ptr_d = (sel == idx_t'(NumInputs - 1)) ? '0 : sel + idx_t'(1);

    always_comb begin
        gnt_o   = '0;
        ready_o = '0;
        valid_o = 1'b0;
        data_o  = '0;
        last_o  = 1'b0;
        if (sel_vld) begin
            gnt_o[sel]   = 1'b1;
            ready_o[sel] = ready_i;
            valid_o      = valid_i[sel];
            data_o       = data_i[sel];
            last_o       = last_i[sel];
        end
    end

    assign hs = valid_o && ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (valid_o) begin
                        if (ready_i && last_o) begin
                            rr_ptr_q  <= rr_ptr_d;
                            pkt_cnt_q <= pkt_cnt_q + CntWidth'(1);
                        end else begin
                            // Lock on a stall too, so the presented flit cannot be re-arbitrated away.
                            state_q    <= LOCKED;
                            lock_idx_q <= sel;
                        end
                    end
                end
                LOCKED: begin
                    if (hs && last_o) begin
                        state_q   <= IDLE;
                        rr_ptr_q  <= rr_ptr_d;
                        pkt_cnt_q <= pkt_cnt_q + CntWidth'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign locked_o  = (state_q == LOCKED);
    assign pkt_cnt_o = pkt_cnt_q;

endmodule

// File: tb/tb_floo_wormhole_arbiter.sv
// Randomized scoreboard bench: a packet-level owner/round-robin model predicts every
// cycle's outputs; a negedge monitor pops and compares. Uses 3 inputs and a 4-bit counter.
module tb_floo_wormhole_arbiter;
    localparam int N  = 3;
    localparam int DW = 16;
    localparam int CW = 4;
    localparam int NCYC = 900;

    logic                 clk, rst_i;
    logic [N-1:0]         valid_i, ready_o, last_i, gnt_o;
    logic [N-1:0][DW-1:0] data_i;
    logic                 valid_o, ready_i, last_o, locked_o;
    logic [DW-1:0]        data_o;
    logic [CW-1:0]        pkt_cnt_o;

    floo_wormhole_arbiter #(.NumInputs(N), .DataWidth(DW), .CntWidth(CW)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
        .last_i(last_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .last_o(last_o),
        .gnt_o(gnt_o), .locked_o(locked_o), .pkt_cnt_o(pkt_cnt_o)
    );

    typedef struct {
        logic [N-1:0]  gnt, rdy;
        logic          vld, last, locked;
        logic [DW-1:0] data;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, failures = 0;

    // Model state: owner of the link (-1 = none), next round-robin start, packet count.
    int owner, rr, cnt;
    // Source state per input: beats left in current packet, presenting a flit now.
    int rem[N];
    bit pres[N];
    bit mid_rst_done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid_o"}, 32'(valid_o), 0);
        chk({tag, "_ready_o"}, 32'(ready_o), 0);
        chk({tag, "_gnt_o"}, 32'(gnt_o), 0);
        chk({tag, "_locked_o"}, 32'(locked_o), 0);
        chk({tag, "_pkt_cnt_o"}, 32'(pkt_cnt_o), 0);
        chk({tag, "_last_o"}, 32'(last_o), 0);
        chk({tag, "_data_o"}, 32'(data_o), 0);
    endtask

    task automatic model_reset();
        owner = -1; rr = 0; cnt = 0;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; pres[i] = 1'b0;
        end
        valid_i = '0; last_i = '0; data_i = '0; ready_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_i) exp_q.delete();
        else if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("gnt_o", 32'(gnt_o), 32'(e.gnt));
            chk("ready_o", 32'(ready_o), 32'(e.rdy));
            chk("valid_o", 32'(valid_o), 32'(e.vld));
            chk("data_o", 32'(data_o), 32'(e.data));
            chk("last_o", 32'(last_o), 32'(e.last));
            chk("locked_o", 32'(locked_o), 32'(e.locked));
            chk("pkt_cnt_o", 32'(pkt_cnt_o), 32'(e.cnt));
        end
    end

    initial begin
        rst_i = 1'b1;
        mid_rst_done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 chk_reset_outputs("reset");
        @(negedge clk);
        #1 rst_i = 1'b0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            exp_t e;
            int   s;
            @(posedge clk);
            #1;
            if (!mid_rst_done && cyc >= 300 && owner >= 0) begin
                // Asynchronous reset in the middle of a locked packet.
                #2 rst_i = 1'b1;
                #1 chk_reset_outputs("midrst");
                mid_rst_done = 1'b1;
                model_reset();
                @(negedge clk);
                #1 rst_i = 1'b0;
                continue;
            end

            // Sources: hold a presented flit until accepted; bubbles only between beats.
            for (int i = 0; i < N; i++) begin
                if (!pres[i]) begin
                    if (rem[i] == 0 && $urandom_range(0, 99) < 45)
                        rem[i] = ($urandom_range(0, 99) < 40) ? 1 : $urandom_range(2, 5);
                    if (rem[i] > 0 && $urandom_range(0, 99) < 70) begin
                        pres[i]   = 1'b1;
                        data_i[i] = DW'($urandom);
                        last_i[i] = (rem[i] == 1);
                    end else begin
                        data_i[i] = DW'($urandom);
                        last_i[i] = 1'($urandom);
                    end
                end
                valid_i[i] = pres[i];
            end
            ready_i = ($urandom_range(0, 99) < 70);

            // Selected input: the packet owner, else the first requester from rr onward.
            s = owner;
            if (s < 0)
                for (int k = 0; k < N; k++)
                    if (s < 0 && valid_i[(rr + k) % N]) s = (rr + k) % N;

            e.gnt = '0; e.rdy = '0; e.vld = 1'b0; e.data = '0; e.last = 1'b0;
            e.locked = (owner >= 0);
            e.cnt = CW'(cnt);
            if (s >= 0) begin
                e.gnt[s] = 1'b1;
                e.rdy[s] = ready_i;
                e.vld    = valid_i[s];
                e.data   = data_i[s];
                e.last   = last_i[s];
            end
            exp_q.push_back(e);

            if (e.vld && ready_i) begin
                pres[s] = 1'b0;
                rem[s]--;
                if (e.last) begin
                    owner = -1;
                    rr    = (s + 1) % N;
                    cnt   = (cnt + 1) % (1 << CW);
                end else owner = s;
            end else if (e.vld) owner = s;
        end

        @(negedge clk);
        #1;
        chk("mid_reset_exercised", 32'(mid_rst_done), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/floo_wormhole_arbiter.md
Name: floo_wormhole_arbiter

Overview:
- Output-port arbiter for the FlooNoC router crossbar.
- Shares one output link between NumInputs input ports, using round-robin selection at packet boundaries.
- Holds the grant (wormhole lock) from the first beat of a packet until its last-beat handshake, so flits of different packets never interleave on a link.
- One instance per output port per physical channel (req, rsp, wide).

Parameters:
- NumInputs, 4, number of competing input ports (>=2, need not be a power of two).
- DataWidth, 64, width of one flit payload in bits.
- CntWidth, 16, width of the completed-packet counter.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, asynchronous, active-high.
- valid_i  input  NumInputs  per-input flit valid.
- ready_o  output  NumInputs  per-input ready.
- data_i  input  NumInputs*DataWidth  per-input flit payload.
- last_i  input  NumInputs  per-input last-beat-of-packet flag.
- valid_o  output  1  output flit valid.
- ready_i  input  1  downstream ready.
- data_o  output  DataWidth  selected payload.
- last_o  output  1  selected last flag.
- gnt_o  output  NumInputs  one-hot current selection; zero when nothing is selected.
- locked_o  output  1  high while in LOCKED.
- pkt_cnt_o  output  CntWidth  completed packets since reset, wrapping.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- State: fsm in {IDLE, LOCKED}, lock_idx, rr_ptr (both range 0..NumInputs-1), pkt_cnt.
- Reset values: fsm=IDLE, lock_idx=0, rr_ptr=0, pkt_cnt=0.
- Outputs at reset with valid_i=0: valid_o=0, ready_o=0, gnt_o=0, locked_o=0, pkt_cnt_o=0, last_o=0, data_o=0.
- Datapath is combinational, with zero latency input to output:
  - valid_o = valid_i[sel]; data_o = data_i[sel]; last_o = last_i[sel].
  - ready_o[sel] = ready_i; all other ready_o bits are 0.
  - When no input is selected, data_o=0 and last_o=0.
- Handshake: a beat transfers when valid_o && ready_i.
- IDLE:
  - sel is the first index j with valid_i[j]=1, searching rr_ptr, rr_ptr+1, ... with wrap at NumInputs.
  - If no valid_i bit is set, there is no selection and gnt_o=0.
  - Handshake with last_o=1 (single-beat packet): stay in IDLE, rr_ptr <= (sel+1) mod NumInputs, pkt_cnt++.
  - valid_o=1 and either no handshake, or handshake with last_o=0: go to LOCKED, lock_idx <= sel. This keeps the output stable while it is stalled.
- LOCKED:
  - sel = lock_idx regardless of other requesters; gnt_o = onehot(lock_idx).
  - Bubble (valid_i[lock_idx]=0): valid_o=0, stay LOCKED, and no other input is granted.
  - Handshake with last_o=1: go to IDLE, rr_ptr <= (lock_idx+1) mod NumInputs, pkt_cnt++.
  - The winner for the next packet is chosen in the following cycle, so there is one arbitration cycle after each multi-beat or stalled packet.
- Wrap: (NumInputs-1)+1 wraps to 0, including for non-power-of-two NumInputs; pkt_cnt wraps from 2^CntWidth-1 to 0.
- Simultaneous requests: only sel is granted; losers see ready_o=0 and must hold valid and data (AXI-style stability).
- A new requester asserting valid during LOCKED is not granted until the locked packet completes.
- Reset mid-packet: immediately returns to IDLE with rr_ptr=0. The lock and the partial packet are abandoned, and upstream/downstream are reset together.
- Requirement on inputs: valid_i must not drop after assertion until its handshake completes. The arbiter tolerates a bubble only in LOCKED.

Test Plan:
- Reset, then valid_i=4'b1111 with all last_i=1 and ready_i=1 for 8 cycles -> gnt_o sequence 0001,0010,0100,1000,0001,...; pkt_cnt_o=8.
- Input 2 sends a 4-beat packet (last on beat 4) while input 0 is valid throughout -> gnt_o=0100 for all 4 beats, locked_o=1 for beats 2-4, then input 0 is granted in the next IDLE cycle.
- Single beat on input 1 with ready_i=0 for 3 cycles, and input 3 raises valid in cycle 2 -> locked_o=1, data_o constant, gnt_o=0010 until the handshake, then rr_ptr=2 and input 3 is granted next.
- LOCKED on input 0 after beat 1 of 3, then valid_i[0]=0 for 2 cycles while input 1 is valid -> valid_o=0, gnt_o=0001, ready_o[1]=0; beats 2-3 complete afterwards.
- NumInputs=3: with rr_ptr=2 and all inputs valid -> input 2 wins and rr_ptr wraps to 0; CntWidth=4 counter wraps 15 to 0 on the 16th packet.
- rst_i asserted asynchronously mid-cycle during beat 2 of 5 -> outputs drop immediately to reset values, locked_o=0, pkt_cnt_o=0; after release, arbitration restarts from input 0.
